// File: rtl/wave_capture_trig_pkg.sv
// Shared definitions for the wave capture engine: FSM state encoding and
// the bit positions inside the trig_mode control word.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        ACTIVE = 2'b01,
        WAIT   = 2'b10
    } state_t;

    // trig_mode[TRIG_POL_BIT]: 0 = rising crossing, 1 = falling crossing
    localparam int TRIG_POL_BIT = 0;
    // trig_mode[TRIG_LVL_BIT]: 0 = compare against zero, 1 = against trig_level
    localparam int TRIG_LVL_BIT = 1;

endpackage

// File: rtl/wave_capture_trig_if.sv
// Bus between the sample source / display side and the capture engine.
// Handshake: sample_valid is a one-cycle strobe with no back-pressure; a
// sample is consumed on every clock edge where sample_valid is high, and
// write_enable marks a RAM write in that same cycle at write_address.
interface wave_capture_trig_if #(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int DECIM_W  = 4
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                display_idle;
    logic [1:0]          trig_mode;
    logic [SAMPLE_W-1:0] trig_level;
    logic [DECIM_W-1:0]  decim;
    logic [ADDR_W:0]     write_address;
    logic                write_enable;
    logic [OUT_W-1:0]    write_sample;
    logic                read_index;
    logic                capture_done;
    logic                auto_trig;

    // Source / display / control side
    modport master (
        output sample_valid, sample_in, display_idle, trig_mode, trig_level, decim,
        input  write_address, write_enable, write_sample, read_index, capture_done, auto_trig
    );

    // Capture engine side
    modport slave (
        input  sample_valid, sample_in, display_idle, trig_mode, trig_level, decim,
        output write_address, write_enable, write_sample, read_index, capture_done, auto_trig
    );
endinterface

// File: rtl/wave_capture_trig_trigger_detect.sv
// Trigger detector: remembers the previous sample and flags a signed
// crossing of the selected level in the cycle the crossing sample arrives.
module trigger_detect
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [1:0]          i_trig_mode,
    input  logic [SAMPLE_W-1:0] i_trig_level,
    output logic                o_trig_event
);
    logic signed [SAMPLE_W-1:0] r_prev;
    logic                       r_prev_valid;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [SAMPLE_W-1:0] w_level;
    logic                       w_rise;
    logic                       w_fall;

    assign w_sample = i_sample;
    assign w_level  = i_trig_mode[TRIG_LVL_BIT] ? i_trig_level : '0;
    assign w_rise   = (r_prev < w_level) && (w_sample >= w_level);
    assign w_fall   = (r_prev >= w_level) && (w_sample < w_level);

    // The reset value of prev is not a real sample, so it may never trigger
    assign o_trig_event = i_sample_valid && r_prev_valid &&
                          (i_trig_mode[TRIG_POL_BIT] ? w_fall : w_rise);

    // Track the last accepted sample regardless of capture state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_sample_valid) begin
            r_prev       <= w_sample;
            r_prev_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/wave_capture_trig.sv
// Double-buffered capture engine: arms, waits for a trigger crossing,
// writes 2**ADDR_W decimated samples into the bank the display is not
// reading, then swaps banks once the display reports idle.
// Optional forced trigger after a sample timeout: WAVE_CAPTURE_AUTO_TRIG_EN.
module wave_capture_trig
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int DECIM_W  = 4
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    ,parameter int AUTO_TIMEOUT = 1024
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    wave_capture_trig_if.slave bus,
    output state_t             o_dbg_state
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_count;
    logic                r_read_index;
    logic [DECIM_W-1:0]  r_decim_q;
    logic [DECIM_W-1:0]  r_dcnt;
    logic                w_trig;
    logic                w_start;
    logic                w_write;
    logic                w_last;

    trigger_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trigger_detect (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (bus.sample_valid),
        .i_sample       (bus.sample_in),
        .i_trig_mode    (bus.trig_mode),
        .i_trig_level   (bus.trig_level),
        .o_trig_event   (w_trig)
    );

    // Writes happen in the same cycle as the accepted strobe
    assign w_write = (r_state == ACTIVE) && bus.sample_valid && (r_dcnt == '0);
    assign w_last  = w_write && (&r_count);

    assign bus.write_enable  = w_write;
    assign bus.capture_done  = w_last;
    assign bus.write_address = {~r_read_index, r_count};
    assign bus.read_index    = r_read_index;
    // Signed to offset binary: flip the sign bit, keep the top magnitude bits
    assign bus.write_sample  = {~bus.sample_in[SAMPLE_W-1], bus.sample_in[SAMPLE_W-2 -: OUT_W-1]};
    assign o_dbg_state       = r_state;

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int TCNT_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_auto_trig;
    logic              w_timeout;

    assign w_timeout = (r_state == ARMED) && bus.sample_valid &&
                       (r_tcnt == TCNT_W'(AUTO_TIMEOUT - 1));
    assign w_start   = w_trig || w_timeout;
    assign bus.auto_trig = r_auto_trig;

    // Count strobes while armed; held at zero in every other state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
        end else if (r_state != ARMED) begin
            r_tcnt <= '0;
        end else if (bus.sample_valid) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Remember how the current capture started; a real trigger beats a tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_trig <= 1'b0;
        end else if (r_state == ARMED) begin
            if (w_trig) begin
                r_auto_trig <= 1'b0;
            end else if (w_timeout) begin
                r_auto_trig <= 1'b1;
            end
        end
    end
`else
    assign w_start       = w_trig;
    assign bus.auto_trig = 1'b0;
`endif

    // Capture FSM with its address, bank and decimation registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARMED;
            r_count      <= '0;
            r_read_index <= 1'b0;
            r_decim_q    <= '0;
            r_dcnt       <= '0;
        end else begin
            case (r_state)
                ARMED: begin
                    r_count <= '0;
                    if (w_start) begin
                        r_state   <= ACTIVE;
                        r_decim_q <= bus.decim;
                        r_dcnt    <= '0;
                    end
                end
                ACTIVE: begin
                    if (bus.sample_valid) begin
                        r_dcnt <= (r_dcnt == r_decim_q) ? '0 : r_dcnt + 1'b1;
                        if (w_write) begin
                            if (w_last) begin
                                r_state <= WAIT;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (bus.display_idle) begin
                        r_read_index <= ~r_read_index;
                        r_count      <= '0;
                        r_state      <= ARMED;
                    end
                end
                default: r_state <= ARMED;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed bench for wave_capture_trig with hand-computed expectations.
module tb_wave_capture_trig;
  import wave_capture_pkg::*;

  logic   clk;
  logic   reset_n;
  state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic       s_we;
  logic [8:0] s_addr;
  logic       s_done;
  logic [7:0] s_ws;

  wave_capture_trig_if #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(8), .DECIM_W(4)) bus ();

  wave_capture_trig #(
    .SAMPLE_W(16), .OUT_W(8), .ADDR_W(8), .DECIM_W(4)
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    ,.AUTO_TIMEOUT(16)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.display_idle = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // one strobe; outputs captured mid-cycle before the active edge
  task automatic strobe(input logic [15:0] s);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in = s;
    #1;
    s_we = bus.write_enable;
    s_addr = bus.write_address;
    s_done = bus.capture_done;
    s_ws = bus.write_sample;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_idle();
    @(negedge clk);
    bus.display_idle = 1'b1;
    @(posedge clk);
    #1;
    bus.display_idle = 1'b0;
  endtask

  task automatic swap_with_sample(input logic [15:0] s);
    @(negedge clk);
    bus.display_idle = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = s;
    @(posedge clk);
    #1;
    bus.display_idle = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARMED); end
    n_cmp++; if (bus.write_address !== 9'h100) begin n_bad++; $display("FAIL reset_addr: got %h expected %h", bus.write_address, 9'h100); end
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", bus.write_enable); end
    n_cmp++; if (bus.capture_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.capture_done); end
    n_cmp++; if (bus.auto_trig !== 1'b0) begin n_bad++; $display("FAIL reset_auto: got %b expected 0", bus.auto_trig); end
    n_cmp++; if (bus.read_index !== 1'b0) begin n_bad++; $display("FAIL reset_ridx: got %b expected 0", bus.read_index); end
    bus.sample_in = 16'h1234;
    #1;
    n_cmp++; if (bus.write_sample !== 8'h92) begin n_bad++; $display("FAIL wsample_pos: got %h expected 92", bus.write_sample); end
    bus.sample_in = 16'hF0FF;
    #1;
    n_cmp++; if (bus.write_sample !== 8'h70) begin n_bad++; $display("FAIL wsample_neg: got %h expected 70", bus.write_sample); end
  endtask

  task automatic test_rising_zero();
    logic [15:0] s;
    bus.trig_mode = 2'b00;
    bus.decim = 4'd0;
    strobe(16'hFFFB);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL rise_m5_state: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'hFFFF);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL rise_m1_state: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd3);
    n_cmp++; if (s_we !== 1'b0) begin n_bad++; $display("FAIL rise_trig_we: got %b expected 0", s_we); end
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL rise_trig_state: got %0d expected %0d", dbg_state, ACTIVE); end
    for (int i = 0; i < 256; i++) begin
      s = {8'(i) ^ 8'h80, 8'h00};
      strobe(s);
      n_cmp++; if (s_we !== 1'b1) begin n_bad++; $display("FAIL rise_we[%0d]: got %b expected 1", i, s_we); end
      n_cmp++; if (s_addr !== 9'(9'h100 + i)) begin n_bad++; $display("FAIL rise_addr[%0d]: got %h expected %h", i, s_addr, 9'(9'h100 + i)); end
      n_cmp++; if (s_done !== (i == 255)) begin n_bad++; $display("FAIL rise_done[%0d]: got %b expected %b", i, s_done, (i == 255)); end
      n_cmp++; if (s_ws !== 8'(i)) begin n_bad++; $display("FAIL rise_ws[%0d]: got %h expected %h", i, s_ws, 8'(i)); end
    end
    n_cmp++; if (dbg_state !== WAIT) begin n_bad++; $display("FAIL rise_end_state: got %0d expected %0d", dbg_state, WAIT); end
    n_cmp++; if (bus.write_address !== 9'h1FF) begin n_bad++; $display("FAIL rise_end_addr: got %h expected 1ff", bus.write_address); end
  endtask

  task automatic test_bank_swap();
    for (int i = 0; i < 50; i++) begin
      strobe(16'(i * 37));
      n_cmp++; if (s_we !== 1'b0 || s_done !== 1'b0) begin n_bad++; $display("FAIL wait_nowrite[%0d]: got we=%b done=%b expected 0 0", i, s_we, s_done); end
    end
    n_cmp++; if (dbg_state !== WAIT) begin n_bad++; $display("FAIL wait_hold_state: got %0d expected %0d", dbg_state, WAIT); end
    pulse_idle();
    n_cmp++; if (bus.read_index !== 1'b1) begin n_bad++; $display("FAIL swap_ridx: got %b expected 1", bus.read_index); end
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL swap_state: got %0d expected %0d", dbg_state, ARMED); end
    n_cmp++; if (bus.write_address !== 9'h000) begin n_bad++; $display("FAIL swap_addr: got %h expected 000", bus.write_address); end
  endtask

  task automatic test_level_falling();
    bus.trig_mode = 2'b11;
    bus.trig_level = 16'd1000;
    strobe(16'd1500);
    strobe(16'd1000);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL lvl_1000_notrig: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd1500);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL lvl_1500_notrig: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd999);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL lvl_999_trig: got %0d expected %0d", dbg_state, ACTIVE); end
    for (int i = 0; i < 256; i++) begin
      strobe(16'(i));
      n_cmp++; if (s_we !== 1'b1) begin n_bad++; $display("FAIL lvl_we[%0d]: got %b expected 1", i, s_we); end
      n_cmp++; if (s_addr !== 9'(i)) begin n_bad++; $display("FAIL lvl_addr[%0d]: got %h expected %h", i, s_addr, 9'(i)); end
      n_cmp++; if (s_done !== (i == 255)) begin n_bad++; $display("FAIL lvl_done[%0d]: got %b expected %b", i, s_done, (i == 255)); end
      n_cmp++; if (s_ws !== 8'h80) begin n_bad++; $display("FAIL lvl_ws[%0d]: got %h expected 80", i, s_ws); end
    end
    n_cmp++; if (dbg_state !== WAIT) begin n_bad++; $display("FAIL lvl_end_state: got %0d expected %0d", dbg_state, WAIT); end
  endtask

  task automatic test_decimation();
    logic exp_we;
    bus.trig_mode = 2'b00;
    bus.decim = 4'd2;
    // swap cycle carries -1, which must still reach prev
    swap_with_sample(16'hFFFF);
    n_cmp++; if (bus.read_index !== 1'b0) begin n_bad++; $display("FAIL dec_ridx: got %b expected 0", bus.read_index); end
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL dec_armed: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd1);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL dec_trig: got %0d expected %0d", dbg_state, ACTIVE); end
    bus.decim = 4'd0;
    for (int i = 0; i < 768; i++) begin
      strobe(16'(i));
      exp_we = (i % 3 == 0) && (i <= 765);
      n_cmp++; if (s_we !== exp_we) begin n_bad++; $display("FAIL dec_we[%0d]: got %b expected %b", i, s_we, exp_we); end
      if (exp_we) begin
        n_cmp++; if (s_addr !== 9'(9'h100 + i / 3)) begin n_bad++; $display("FAIL dec_addr[%0d]: got %h expected %h", i, s_addr, 9'(9'h100 + i / 3)); end
      end
      n_cmp++; if (s_done !== (i == 765)) begin n_bad++; $display("FAIL dec_done[%0d]: got %b expected %b", i, s_done, (i == 765)); end
    end
    n_cmp++; if (dbg_state !== WAIT) begin n_bad++; $display("FAIL dec_end_state: got %0d expected %0d", dbg_state, WAIT); end
    n_cmp++; if (bus.write_address !== 9'h1FF) begin n_bad++; $display("FAIL dec_end_addr: got %h expected 1ff", bus.write_address); end
    pulse_idle();
    n_cmp++; if (bus.read_index !== 1'b1) begin n_bad++; $display("FAIL dec_swap_ridx: got %b expected 1", bus.read_index); end
  endtask

  task automatic test_mid_reset();
    bus.trig_mode = 2'b00;
    strobe(16'hFFFF);
    strobe(16'd1);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL mid_trig: got %0d expected %0d", dbg_state, ACTIVE); end
    for (int i = 0; i < 100; i++) strobe(16'(i));
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'd5;
    #1;
    n_cmp++; if (bus.write_address !== 9'h064 || bus.write_enable !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got addr=%h we=%b expected 064 1", bus.write_address, bus.write_enable); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL mid_we: got %b expected 0", bus.write_enable); end
    n_cmp++; if (bus.capture_done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b expected 0", bus.capture_done); end
    n_cmp++; if (bus.write_address !== 9'h100) begin n_bad++; $display("FAIL mid_addr: got %h expected 100", bus.write_address); end
    n_cmp++; if (bus.read_index !== 1'b0) begin n_bad++; $display("FAIL mid_ridx: got %b expected 0", bus.read_index); end
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, ARMED); end
    n_cmp++; if (bus.auto_trig !== 1'b0) begin n_bad++; $display("FAIL mid_auto: got %b expected 0", bus.auto_trig); end
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_sample();
    // falling vs zero: a reset prev of 0 followed by -1 would look like a crossing
    do_reset();
    bus.trig_mode = 2'b01;
    strobe(16'hFFFF);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL first_fall_notrig: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd5);
    strobe(16'hFFFE);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL first_fall_trig: got %0d expected %0d", dbg_state, ACTIVE); end
    do_reset();
    bus.trig_mode = 2'b00;
    strobe(16'hFFFF);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL first_rise_notrig: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd2);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL first_rise_trig: got %0d expected %0d", dbg_state, ACTIVE); end
  endtask

  task automatic test_auto_trig();
    do_reset();
    bus.trig_mode = 2'b00;
    bus.decim = 4'd0;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    for (int i = 0; i < 15; i++) strobe(16'd5);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL auto_15_state: got %0d expected %0d", dbg_state, ARMED); end
    strobe(16'd5);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL auto_16_state: got %0d expected %0d", dbg_state, ACTIVE); end
    n_cmp++; if (bus.auto_trig !== 1'b1) begin n_bad++; $display("FAIL auto_flag_set: got %b expected 1", bus.auto_trig); end
    for (int i = 0; i < 256; i++) strobe(16'd5);
    n_cmp++; if (dbg_state !== WAIT || bus.auto_trig !== 1'b1) begin n_bad++; $display("FAIL auto_wait_hold: got state=%0d auto=%b expected %0d 1", dbg_state, bus.auto_trig, WAIT); end
    pulse_idle();
    for (int i = 0; i < 14; i++) strobe(16'd5);
    strobe(16'hFFFF);
    strobe(16'd1);
    n_cmp++; if (dbg_state !== ACTIVE) begin n_bad++; $display("FAIL auto_tie_state: got %0d expected %0d", dbg_state, ACTIVE); end
    n_cmp++; if (bus.auto_trig !== 1'b0) begin n_bad++; $display("FAIL auto_tie_flag: got %b expected 0", bus.auto_trig); end
`else
    for (int i = 0; i < 20; i++) strobe(16'd5);
    n_cmp++; if (dbg_state !== ARMED) begin n_bad++; $display("FAIL noauto_state: got %0d expected %0d", dbg_state, ARMED); end
    n_cmp++; if (bus.auto_trig !== 1'b0) begin n_bad++; $display("FAIL noauto_flag: got %b expected 0", bus.auto_trig); end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.display_idle = 1'b0;
    bus.trig_mode = 2'b00;
    bus.trig_level = '0;
    bus.decim = '0;
    test_reset();
    test_rising_zero();
    test_bank_swap();
    test_level_falling();
    test_decimation();
    test_mid_reset();
    test_first_sample();
    test_auto_trig();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
